// File: rtl/capture_scheduler_if.sv
//============================================================================
// Module      : capture_scheduler_if
// Description : Request, camera-status and grant/status signals shared
//               between the capture scheduler and its environment.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface capture_scheduler_if;
    // Requests and camera status (into the scheduler)
    logic       Req_manual;
    logic       Auto_en;
    logic [7:0] Period;
    logic       Exp_up_req;
    logic       Exp_down_req;
    logic       Cam_Expose;
    logic       Cam_ADC;

    // Commands, grants and status (out of the scheduler)
    logic       Init;
    logic       Exp_increase;
    logic       Exp_decrease;
    logic       Ack_manual;
    logic       Ack_auto;
    logic       Frame_done;
    logic       Error;
    logic       Busy;
    logic [7:0] Drop_count;

    // Environment side: issues requests, observes grants
    modport master (
        output Req_manual, Auto_en, Period, Exp_up_req, Exp_down_req,
               Cam_Expose, Cam_ADC,
        input  Init, Exp_increase, Exp_decrease, Ack_manual, Ack_auto,
               Frame_done, Error, Busy, Drop_count
    );

    // Scheduler side
    modport slave (
        input  Req_manual, Auto_en, Period, Exp_up_req, Exp_down_req,
               Cam_Expose, Cam_ADC,
        output Init, Exp_increase, Exp_decrease, Ack_manual, Ack_auto,
               Frame_done, Error, Busy, Drop_count
    );
endinterface

`default_nettype wire

// File: rtl/capture_scheduler.sv
//============================================================================
// Module      : capture_scheduler
// Description : Arbitrates manual captures, periodic auto captures and
//               exposure steps for a camera controller; tracks the frame
//               handshake (Expose / ADC) with an expose-start timeout and
//               counts auto ticks lost while a tick is still pending.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module capture_scheduler (
    input wire                  Clk,
    input wire                  Reset,
    capture_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADJUST   = 3'd1,
        S_INIT     = 3'd2,
        S_WAIT_EXP = 3'd3,
        S_WAIT_ADC = 3'd4,
        S_WAIT_END = 3'd5
    } state_t;

    // Timeout counter value seen on the 16th WAIT_EXP cycle
    localparam logic [3:0] c_TMO_LAST = 4'd15;

    state_t     r_state;
    state_t     w_state_nxt;

    // Pending request flags
    logic       r_man_pend;
    logic       r_auto_pend;
    logic       r_up_pend;
    logic       r_dn_pend;

    // Counters
    logic [7:0] r_auto_cnt;
    logic [7:0] w_auto_cnt_nxt;
    logic [3:0] r_tmo_cnt;
    logic [3:0] w_tmo_nxt;
    logic [7:0] r_drop;

    // Registered outputs
    logic       r_init;
    logic       r_exp_inc;
    logic       r_exp_dec;
    logic       r_ack_man;
    logic       r_ack_auto;
    logic       r_frame_done;
    logic       r_error;
    logic       r_busy;

    // Next values of the registered outputs and flag clears
    logic       w_init_nxt;
    logic       w_inc_nxt;
    logic       w_dec_nxt;
    logic       w_ack_man_nxt;
    logic       w_ack_auto_nxt;
    logic       w_done_nxt;
    logic       w_err_nxt;
    logic       w_clr_man;
    logic       w_clr_auto;
    logic       w_clr_up;
    logic       w_clr_dn;

    logic       w_timer_on;
    logic       w_tick;

    // Auto timer: free-runs 0..Period-1 while enabled, otherwise parked at 0.
    // The >= compare recovers cleanly if Period shrinks below the count.
    always_comb begin
        w_timer_on     = bus.Auto_en && (bus.Period != 8'd0);
        w_tick         = w_timer_on && (r_auto_cnt >= (bus.Period - 8'd1));
        w_auto_cnt_nxt = 8'd0;
        if (w_timer_on && !w_tick) begin
            w_auto_cnt_nxt = r_auto_cnt + 8'd1;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt    = r_state;
        w_tmo_nxt      = r_tmo_cnt;
        w_init_nxt     = 1'b0;
        w_inc_nxt      = 1'b0;
        w_dec_nxt      = 1'b0;
        w_ack_man_nxt  = 1'b0;
        w_ack_auto_nxt = 1'b0;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_clr_man      = 1'b0;
        w_clr_auto     = 1'b0;
        w_clr_up       = 1'b0;
        w_clr_dn       = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Opposing exposure requests cancel each other silently
                if (r_up_pend && r_dn_pend) begin
                    w_clr_up = 1'b1;
                    w_clr_dn = 1'b1;
                end
                if (r_up_pend ^ r_dn_pend) begin
                    w_state_nxt = S_ADJUST;
                    w_inc_nxt   = r_up_pend;
                    w_dec_nxt   = r_dn_pend;
                end else if (r_man_pend) begin
                    w_state_nxt   = S_INIT;
                    w_init_nxt    = 1'b1;
                    w_ack_man_nxt = 1'b1;
                end else if (r_auto_pend) begin
                    w_state_nxt    = S_INIT;
                    w_init_nxt     = 1'b1;
                    w_ack_auto_nxt = 1'b1;
                end
            end

            S_ADJUST: begin
                // The step pulse currently on the output names the flag served
                w_clr_up    = r_exp_inc;
                w_clr_dn    = r_exp_dec;
                w_state_nxt = S_IDLE;
            end

            S_INIT: begin
                // The ack currently on the output names the source granted
                w_clr_man   = r_ack_man;
                w_clr_auto  = r_ack_auto;
                w_tmo_nxt   = 4'd0;
                w_state_nxt = S_WAIT_EXP;
            end

            S_WAIT_EXP: begin
                if (bus.Cam_Expose) begin
                    w_state_nxt = S_WAIT_ADC;
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmo_nxt = r_tmo_cnt + 4'd1;
                end
            end

            S_WAIT_ADC: begin
                if (bus.Cam_ADC) begin
                    w_state_nxt = S_WAIT_END;
                end
            end

            S_WAIT_END: begin
                if (!bus.Cam_ADC) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, timer and timeout counter registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_auto_cnt <= 8'd0;
            r_tmo_cnt  <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_auto_cnt <= w_auto_cnt_nxt;
            r_tmo_cnt  <= w_tmo_nxt;
        end
    end

    // Pending flags: a new request always wins over a same-cycle clear so it
    // carries into the next frame
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_man_pend  <= 1'b0;
            r_auto_pend <= 1'b0;
            r_up_pend   <= 1'b0;
            r_dn_pend   <= 1'b0;
        end else begin
            r_man_pend  <= bus.Req_manual   | (r_man_pend  & ~w_clr_man);
            r_auto_pend <= w_tick           | (r_auto_pend & ~w_clr_auto);
            r_up_pend   <= bus.Exp_up_req   | (r_up_pend   & ~w_clr_up);
            r_dn_pend   <= bus.Exp_down_req | (r_dn_pend   & ~w_clr_dn);
        end
    end

    // Drop counter: a tick landing on an auto request that is still pending
    // (and not being granted this cycle) is lost; saturates at 255
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_drop <= 8'd0;
        end else if (w_tick && r_auto_pend && !w_clr_auto && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    // Output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_init       <= 1'b0;
            r_exp_inc    <= 1'b0;
            r_exp_dec    <= 1'b0;
            r_ack_man    <= 1'b0;
            r_ack_auto   <= 1'b0;
            r_frame_done <= 1'b0;
            r_error      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_init       <= w_init_nxt;
            r_exp_inc    <= w_inc_nxt;
            r_exp_dec    <= w_dec_nxt;
            r_ack_man    <= w_ack_man_nxt;
            r_ack_auto   <= w_ack_auto_nxt;
            r_frame_done <= w_done_nxt;
            r_error      <= w_err_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

    assign bus.Init         = r_init;
    assign bus.Exp_increase = r_exp_inc;
    assign bus.Exp_decrease = r_exp_dec;
    assign bus.Ack_manual   = r_ack_man;
    assign bus.Ack_auto     = r_ack_auto;
    assign bus.Frame_done   = r_frame_done;
    assign bus.Error        = r_error;
    assign bus.Busy         = r_busy;
    assign bus.Drop_count   = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_capture_scheduler.sv
//============================================================================
// Module      : tb_capture_scheduler
// Description : Directed self-checking bench for capture_scheduler.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_capture_scheduler;

    logic Clk = 1'b0;
    logic Reset;
    int   n_chk = 0;
    int   n_bad = 0;

    capture_scheduler_if bus ();

    capture_scheduler dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // Advance one clock; inputs set after this are sampled on the next edge
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called on the Init cycle: quick camera response, Frame_done 4 cycles on
    task automatic do_frame(input string tag);
        step();
        bus.Cam_Expose = 1'b1;
        step();
        bus.Cam_Expose = 1'b0;
        bus.Cam_ADC    = 1'b1;
        step();
        bus.Cam_ADC    = 1'b0;
        chk({tag, "_busy"}, bus.Busy, 1);
        step();
        chk({tag, "_done"}, bus.Frame_done, 1);
    endtask

    logic seen_err;

    initial begin
        Reset            = 1'b1;
        bus.Req_manual   = 1'b0;
        bus.Auto_en      = 1'b0;
        bus.Period       = 8'd0;
        bus.Exp_up_req   = 1'b0;
        bus.Exp_down_req = 1'b0;
        bus.Cam_Expose   = 1'b0;
        bus.Cam_ADC      = 1'b0;
        repeat (3) step();
        chk("rst_busy",  bus.Busy, 0);
        chk("rst_init",  bus.Init, 0);
        chk("rst_drop",  bus.Drop_count, 0);
        chk("rst_error", bus.Error, 0);
        Reset = 1'b0;
        step();

        // ---- manual capture: Expose 3 cycles after Init, ADC high 5 cycles
        bus.Req_manual = 1'b1;
        step();
        bus.Req_manual = 1'b0;
        chk("man_not_yet", bus.Init, 0);
        step();
        chk("man_init",    bus.Init, 1);
        chk("man_ack",     bus.Ack_manual, 1);
        chk("man_no_auto", bus.Ack_auto, 0);
        chk("man_busy",    bus.Busy, 1);
        step();
        chk("man_init_1cy", bus.Init, 0);
        step();
        step();
        bus.Cam_Expose = 1'b1;
        step();
        bus.Cam_Expose = 1'b0;
        bus.Cam_ADC    = 1'b1;
        repeat (5) step();
        bus.Cam_ADC = 1'b0;
        chk("man_done_early", bus.Frame_done, 0);
        chk("man_busy_end",   bus.Busy, 1);
        step();
        chk("man_done",  bus.Frame_done, 1);
        chk("man_idle",  bus.Busy, 0);
        step();
        chk("man_done_1cy", bus.Frame_done, 0);

        // ---- priority: manual, exposure-up and an auto tick together
        bus.Req_manual = 1'b1;
        bus.Exp_up_req = 1'b1;
        bus.Period     = 8'd1;
        bus.Auto_en    = 1'b1;
        step();
        bus.Req_manual = 1'b0;
        bus.Exp_up_req = 1'b0;
        bus.Auto_en    = 1'b0;
        step();
        chk("pri_inc",      bus.Exp_increase, 1);
        chk("pri_no_dec",   bus.Exp_decrease, 0);
        chk("pri_no_init",  bus.Init, 0);
        step();
        chk("pri_inc_1cy",  bus.Exp_increase, 0);
        step();
        chk("pri_man_init", bus.Init, 1);
        chk("pri_man_ack",  bus.Ack_manual, 1);
        chk("pri_man_noauto", bus.Ack_auto, 0);
        do_frame("pri_f1");
        step();
        chk("pri_auto_init", bus.Init, 1);
        chk("pri_auto_ack",  bus.Ack_auto, 1);
        do_frame("pri_f2");
        chk("pri_drop", bus.Drop_count, 0);

        // ---- conflict: up and down together cancel; down flag must be gone
        bus.Exp_up_req   = 1'b1;
        bus.Exp_down_req = 1'b1;
        step();
        bus.Exp_up_req   = 1'b0;
        bus.Exp_down_req = 1'b0;
        step();
        chk("cf_no_inc", bus.Exp_increase, 0);
        chk("cf_no_dec", bus.Exp_decrease, 0);
        chk("cf_idle",   bus.Busy, 0);
        bus.Exp_up_req = 1'b1;
        step();
        bus.Exp_up_req = 1'b0;
        step();
        chk("cf_up_after", bus.Exp_increase, 1);
        bus.Exp_down_req = 1'b1;
        step();
        bus.Exp_down_req = 1'b0;
        step();
        chk("cf_dec",       bus.Exp_decrease, 1);
        chk("cf_dec_noinc", bus.Exp_increase, 0);
        step();

        // ---- timeout: Expose never rises
        bus.Req_manual = 1'b1;
        step();
        bus.Req_manual = 1'b0;
        step();
        chk("to_init", bus.Init, 1);
        seen_err = 1'b0;
        repeat (16) begin
            step();
            seen_err = seen_err | bus.Error;
        end
        chk("to_no_early_err", seen_err, 0);
        chk("to_busy16",       bus.Busy, 1);
        step();
        chk("to_error",   bus.Error, 1);
        chk("to_idle",    bus.Busy, 0);
        chk("to_no_done", bus.Frame_done, 0);
        step();
        chk("to_err_1cy", bus.Error, 0);

        // ---- drops: Period=4, stall in WAIT_ADC for 20 cycles
        bus.Req_manual = 1'b1;
        bus.Period     = 8'd4;
        bus.Auto_en    = 1'b1;
        step();
        bus.Req_manual = 1'b0;
        step();
        chk("dr_init", bus.Ack_manual, 1);
        bus.Cam_Expose = 1'b1;
        step();
        step();
        bus.Cam_Expose = 1'b0;
        repeat (19) step();
        bus.Cam_ADC = 1'b1;
        bus.Auto_en = 1'b0;
        step();
        chk("dr_count", bus.Drop_count, 4);
        bus.Cam_ADC = 1'b0;
        step();
        chk("dr_done", bus.Frame_done, 1);
        step();
        chk("dr_auto_ack", bus.Ack_auto, 1);
        do_frame("dr_f");
        step();
        chk("dr_one_only", bus.Init, 0);
        chk("dr_idle",     bus.Busy, 0);

        // ---- saturation of the drop counter
        bus.Req_manual = 1'b1;
        step();
        bus.Req_manual = 1'b0;
        step();
        bus.Cam_Expose = 1'b1;
        step();
        step();
        bus.Cam_Expose = 1'b0;
        bus.Period     = 8'd1;
        bus.Auto_en    = 1'b1;
        repeat (300) step();
        bus.Auto_en = 1'b0;
        chk("sat_255", bus.Drop_count, 255);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("sat_rst_drop", bus.Drop_count, 0);
        step();

        // ---- reset mid-frame in WAIT_ADC with Drop_count=7
        bus.Req_manual = 1'b1;
        step();
        bus.Req_manual = 1'b0;
        step();
        bus.Cam_Expose = 1'b1;
        step();
        step();
        bus.Cam_Expose = 1'b0;
        bus.Auto_en    = 1'b1;
        repeat (8) step();
        bus.Auto_en = 1'b0;
        chk("mr_drop7", bus.Drop_count, 7);
        Reset       = 1'b1;
        bus.Cam_ADC = 1'b1;
        step();
        Reset       = 1'b0;
        bus.Cam_ADC = 1'b0;
        chk("mr_busy",  bus.Busy, 0);
        chk("mr_drop",  bus.Drop_count, 0);
        chk("mr_done",  bus.Frame_done, 0);
        chk("mr_err",   bus.Error, 0);
        step();
        step();
        chk("mr_no_auto", bus.Init, 0);
        chk("mr_no_done", bus.Frame_done, 0);
        bus.Req_manual = 1'b1;
        step();
        bus.Req_manual = 1'b0;
        step();
        chk("mr_man_init", bus.Init, 1);
        chk("mr_man_ack",  bus.Ack_manual, 1);
        do_frame("mr_f");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
